// File: rtl/serial_rx_hex.sv
// UART 8N1 receiver that parses "HH\n" ASCII hex lines into bytes.
// Malformed text or a bad stop bit gives a one-cycle error strobe; parsing resyncs on LF.
//
// Receiver states
//   state       | meaning
//   RX_IDLE     | line idle, waiting for a falling edge on rx_s
//   RX_START    | timing to mid start bit, rejecting glitches
//   RX_DATA     | sampling 8 data bits LSB-first
//   RX_STOP     | sampling the stop bit
//   RX_WAITHIGH | framing error seen, waiting for the line to return high
// Parser states
//   state       | meaning
//   P_HI        | expect high nibble (LF here is an empty line)
//   P_LO        | expect low nibble
//   P_LF        | expect LF to commit the byte
//   P_SKIP      | discard chars until LF
module serial_rx_hex #(
  parameter int COUNTER_BITS = 8,
  parameter int DELAY        = 234
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       serial_in_i,
  output logic [7:0] data_o,
  output logic       data_valid_o,
  output logic       error_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAITHIGH
  } rx_state_e;

  typedef enum logic [1:0] {
    P_HI,
    P_LO,
    P_LF,
    P_SKIP
  } p_state_e;

  localparam logic [COUNTER_BITS-1:0] CNT_FULL = COUNTER_BITS'(DELAY - 1);
  localparam logic [COUNTER_BITS-1:0] CNT_HALF = COUNTER_BITS'(DELAY / 2 - 1);
  localparam logic [COUNTER_BITS-1:0] CNT_ONE  = COUNTER_BITS'(1);
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;

  logic                    sync1_q, rx_s_q;
  rx_state_e               rx_state_q, rx_state_d;
  logic [COUNTER_BITS-1:0] cnt_q, cnt_d;
  logic [2:0]              bit_idx_q, bit_idx_d;
  logic [7:0]              shift_q, shift_d;
  logic                    char_strobe_q, char_strobe_d;
  logic [7:0]              char_q, char_d;
  logic                    frame_err;

  p_state_e                p_state_q, p_state_d;
  logic [3:0]              hi_q, hi_d;
  logic [3:0]              lo_q, lo_d;
  logic [7:0]              data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    error_q, error_d;
  logic                    parse_err;

  function automatic logic is_hex(input logic [7:0] c);
    return ((c >= 8'h30) && (c <= 8'h39)) ||
           ((c >= 8'h41) && (c <= 8'h46)) ||
           ((c >= 8'h61) && (c <= 8'h66));
  endfunction

  // Only meaningful when is_hex(c); letters map via their low nibble + 9.
  function automatic logic [3:0] hex_val(input logic [7:0] c);
    if (c <= 8'h39) return c[3:0];
    return c[3:0] + 4'd9;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= serial_in_i;
      rx_s_q  <= sync1_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_state_q    <= RX_IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      char_strobe_q <= 1'b0;
      char_q        <= '0;
    end else begin
      rx_state_q    <= rx_state_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      char_strobe_q <= char_strobe_d;
      char_q        <= char_d;
    end
  end

  always_comb begin
    rx_state_d    = rx_state_q;
    cnt_d         = cnt_q + CNT_ONE;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    char_strobe_d = 1'b0;
    char_d        = char_q;
    frame_err     = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (!rx_s_q) begin
          cnt_d      = '0;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (cnt_q == CNT_HALF) begin
          if (!rx_s_q) begin
            cnt_d      = '0;
            bit_idx_d  = '0;
            rx_state_d = RX_DATA;
          end else begin
            rx_state_d = RX_IDLE;
          end
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_FULL) begin
          shift_d   = {rx_s_q, shift_q[7:1]};
          cnt_d     = '0;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == CNT_FULL) begin
          if (rx_s_q) begin
            char_strobe_d = 1'b1;
            char_d        = shift_q;
            rx_state_d    = RX_IDLE;
          end else begin
            frame_err  = 1'b1;
            rx_state_d = RX_WAITHIGH;
          end
        end
      end
      RX_WAITHIGH: begin
        if (rx_s_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      p_state_q <= P_HI;
      hi_q      <= '0;
      lo_q      <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      p_state_q <= p_state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
    end
  end

  always_comb begin
    p_state_d = p_state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    parse_err = 1'b0;
    if (char_strobe_q && (char_q != CH_CR)) begin
      unique case (p_state_q)
        P_HI: begin
          if (is_hex(char_q)) begin
            hi_d      = hex_val(char_q);
            p_state_d = P_LO;
          end else if (char_q != CH_LF) begin
            parse_err = 1'b1;
            p_state_d = P_SKIP;
          end
        end
        P_LO: begin
          if (is_hex(char_q)) begin
            lo_d      = hex_val(char_q);
            p_state_d = P_LF;
          end else begin
            parse_err = 1'b1;
            p_state_d = (char_q == CH_LF) ? P_HI : P_SKIP;
          end
        end
        P_LF: begin
          if (char_q == CH_LF) begin
            data_d    = {hi_q, lo_q};
            valid_d   = 1'b1;
            p_state_d = P_HI;
          end else begin
            parse_err = 1'b1;
            p_state_d = P_SKIP;
          end
        end
        P_SKIP: begin
          if (char_q == CH_LF) p_state_d = P_HI;
        end
        default: p_state_d = P_HI;
      endcase
    end
    // A framing error and a charStrobe can never coincide, so one error per char holds.
    error_d = frame_err | parse_err;
  end

  assign data_o       = data_q;
  assign data_valid_o = valid_q;
  assign error_o      = error_q;
  assign busy_o       = (rx_state_q != RX_IDLE);

endmodule

// File: tb/tb_serial_rx_hex.sv
// Bench for serial_rx_hex: drives 8N1 frames at DELAY=8 and scoreboards parsed bytes and error strobes.
module tb_serial_rx_hex;

  localparam int DELAY = 8;
  localparam int CB    = 4;

  logic       clk;
  logic       rst_n;
  logic       serial;
  logic [7:0] data;
  logic       data_valid;
  logic       error;
  logic       busy;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int         err_seen  = 0;
  int         both_seen = 0;

  serial_rx_hex #(.COUNTER_BITS(CB), .DELAY(DELAY)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .serial_in_i  (serial),
    .data_o       (data),
    .data_valid_o (data_valid),
    .error_o      (error),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor only records; comparisons happen in the test tasks.
  always @(negedge clk) begin
    if (data_valid) obs_q.push_back(data);
    if (error) err_seen++;
    if (data_valid && error) both_seen++;
  end

  task automatic send_frame(input logic [7:0] ch, input logic stop_b);
    serial = 1'b0;
    repeat (DELAY) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      serial = ch[i];
      repeat (DELAY) @(negedge clk);
    end
    serial = stop_b;
    repeat (DELAY) @(negedge clk);
    if (stop_b) serial = 1'b1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_frame(s[i], 1'b1);
  endtask

  task automatic test_reset();
    serial = 1'b1;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", data); end
    n_cmp++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dv got %b want 0", data_valid); end
    n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", error); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_basic();
    int e0;
    e0 = err_seen;
    exp_q.push_back(8'h3A);
    send_str("3A\n");
    repeat (20) @(negedge clk);
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL basic_dv_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [7:0] o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_cmp++; if (o !== e) begin n_fail++; $display("FAIL basic_data got %h want %h", o, e); end
    end
    n_cmp++; if (err_seen - e0 != 0) begin n_fail++; $display("FAIL basic_err got %0d want 0", err_seen - e0); end
    n_cmp++; if (data !== 8'h3A) begin n_fail++; $display("FAIL basic_hold got %h want 3a", data); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy got %b want 0", busy); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_cr_lower();
    int e0;
    e0 = err_seen;
    exp_q.push_back(8'hFF);
    send_str("ff\r\n");
    repeat (20) @(negedge clk);
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL cr_dv_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [7:0] o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_cmp++; if (o !== e) begin n_fail++; $display("FAIL cr_data got %h want %h", o, e); end
    end
    n_cmp++; if (err_seen - e0 != 0) begin n_fail++; $display("FAIL cr_err got %0d want 0", err_seen - e0); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_parse_err();
    int e0;
    e0 = err_seen;
    send_str("G1\n");
    repeat (10) @(negedge clk);
    n_cmp++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL perr_no_dv got %0d want 0", obs_q.size()); end
    n_cmp++; if (err_seen - e0 != 1) begin n_fail++; $display("FAIL perr_err got %0d want 1", err_seen - e0); end
    exp_q.push_back(8'h05);
    send_str("05\n");
    repeat (20) @(negedge clk);
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL perr_dv_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [7:0] o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_cmp++; if (o !== e) begin n_fail++; $display("FAIL perr_data got %h want %h", o, e); end
    end
    n_cmp++; if (err_seen - e0 != 1) begin n_fail++; $display("FAIL perr_err_total got %0d want 1", err_seen - e0); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_framing();
    int e0;
    e0 = err_seen;
    send_frame(8'h41, 1'b0);
    repeat (20) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL frame_busy_low got %b want 1", busy); end
    n_cmp++; if (err_seen - e0 != 1) begin n_fail++; $display("FAIL frame_err got %0d want 1", err_seen - e0); end
    serial = 1'b1;
    repeat (2 * DELAY) @(negedge clk);
    send_str("7\n");
    repeat (20) @(negedge clk);
    n_cmp++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL frame_no_dv got %0d want 0", obs_q.size()); end
    n_cmp++; if (err_seen - e0 != 2) begin n_fail++; $display("FAIL frame_err_total got %0d want 2", err_seen - e0); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_glitch();
    int e0;
    e0 = err_seen;
    serial = 1'b0;
    repeat (3) @(negedge clk);
    serial = 1'b1;
    repeat (DELAY + 4) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy got %b want 0", busy); end
    n_cmp++; if (obs_q.size() != 0 || err_seen != e0) begin n_fail++; $display("FAIL glitch_strobe got dv=%0d err=%0d want 0/0", obs_q.size(), err_seen - e0); end
    exp_q.push_back(8'h12);
    send_str("12\n");
    repeat (20) @(negedge clk);
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL glitch_dv_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [7:0] o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_cmp++; if (o !== e) begin n_fail++; $display("FAIL glitch_data got %h want %h", o, e); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    int e0;
    logic [7:0] ch;
    ch = 8'h39;
    send_str("8");
    repeat (4) @(negedge clk);
    serial = 1'b0;
    repeat (DELAY) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      serial = ch[i];
      repeat (DELAY) @(negedge clk);
    end
    serial = ch[4];
    repeat (DELAY / 2) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (data !== 8'h00 || data_valid !== 1'b0 || error !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midrst_outputs got data=%h dv=%b err=%b busy=%b want 00/0/0/0", data, data_valid, error, busy);
    end
    serial = 1'b1;
    repeat (DELAY) @(negedge clk);
    n_cmp++; if (data !== 8'h00 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_hold got data=%h busy=%b want 00/0", data, busy); end
    rst_n = 1'b1;
    repeat (2 * DELAY) @(negedge clk);
    e0 = err_seen;
    n_cmp++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL midrst_no_dv got %0d want 0", obs_q.size()); end
    exp_q.push_back(8'hAB);
    send_str("AB\n");
    repeat (20) @(negedge clk);
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL midrst_dv_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [7:0] o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_cmp++; if (o !== e) begin n_fail++; $display("FAIL midrst_data got %h want %h", o, e); end
    end
    n_cmp++; if (err_seen - e0 != 0) begin n_fail++; $display("FAIL midrst_err got %0d want 0", err_seen - e0); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    exp_q.push_back(8'hC4);
    exp_q.push_back(8'h0E);
    send_str("c4\n0E\n");
    repeat (20) @(negedge clk);
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_dv_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [7:0] o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_cmp++; if (o !== e) begin n_fail++; $display("FAIL b2b_data got %h want %h", o, e); end
    end
    n_cmp++; if (both_seen != 0) begin n_fail++; $display("FAIL dv_err_overlap got %0d want 0", both_seen); end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cr_lower();
    test_parse_err();
    test_framing();
    test_glitch();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_rx_hex.md
# serial_rx_hex

Receive-side counterpart of the hex debug transmitter. It is a UART 8N1 receiver that parses ASCII hex text into bytes: two hex digits followed by LF yield one byte on `data` with a one-cycle `dataValid` strobe. Malformed input raises a one-cycle `error` strobe and resynchronises on the next LF. It sits between the board's serial RX pin and debug/control logic that needs to be poked from a host terminal.

## Interface
- `counterBits`, 8, width of the bit-timing counter; must hold `delay-1`.
- `delay`, 234, clocks per bit (27 MHz / 115200 baud).
- `clk`  input  1  system clock; all logic on the rising edge.
- `resetN`  input  1  asynchronous, active-low reset.
- `serialIn`  input  1  UART line; idles high; asynchronous to `clk`.
- `data`  output  8  last parsed byte; holds its value until the next `dataValid`.
- `dataValid`  output  1  one-cycle strobe when `data` is updated.
- `error`  output  1  one-cycle strobe on a framing error or a parse error.
- `busy`  output  1  high while a character frame is being received.

## Operation
- Reset values: `data`=0x00, `dataValid`=0, `error`=0, `busy`=0. Both the receiver and the parser start in their idle states. The synchroniser flops reset to 1.
- `serialIn` passes through a 2-flop synchroniser. All further use is of the synchronised value `rxS`.
- Receiver FSM states: IDLE, START, DATA, STOP, WAITHIGH.
  - IDLE: when `rxS`=0, clear the counter and go to START.
  - START: on counter = `delay/2 - 1` (integer division), check `rxS`. If 0, clear the counter, set bit index 0 and go to DATA. If 1, this is a false start; go to IDLE with no strobe.
  - DATA: on counter = `delay-1`, shift `rxS` into the shift register LSB-first and clear the counter. After bit 7, go to STOP.
  - STOP: on counter = `delay-1`, check `rxS`. If 1, emit an internal `charStrobe` with the char for one cycle and go to IDLE. If 0, this is a framing error: pulse `error`, drop the char, go to WAITHIGH.
  - WAITHIGH: when `rxS`=1, go to IDLE.
  - In every other cycle the counter increments.
  - `busy` = 1 in START, DATA, STOP and WAITHIGH.
- Parser FSM states: P0 (expect high nibble), P1 (expect low nibble), P2 (expect LF), SKIP (discard until LF). It acts only on `charStrobe`.
  - Hex digits are '0'-'9', 'A'-'F' and 'a'-'f'. CR (0x0D) is ignored in every state.
  - P0: on a hex digit, latch the high nibble and go to P1. On LF, stay in P0 (empty line, no strobe). On anything else, pulse `error` and go to SKIP.
  - P1: on a hex digit, latch the low nibble and go to P2. On LF, pulse `error` and go to P0. On anything else, pulse `error` and go to SKIP.
  - P2: on LF, load `data` with {hi, lo}, pulse `dataValid` and go to P0. On anything else, pulse `error` and go to SKIP.
  - SKIP: on LF, go to P0. All other chars are ignored without an error.
- A framing error does not change the parser state.
- At most one `error` pulse per char. `dataValid` and `error` are never high in the same cycle.

## Timing
- Input-to-FSM latency is 2 clocks (synchroniser).
- After the START transition, the start bit is checked `delay/2` clocks later. Each data bit and the stop bit is sampled `delay` clocks after the previous sample.
- `charStrobe` is high in the cycle after the stop-bit sample edge.
- `dataValid` or a parse `error` is registered 1 clock after `charStrobe`.
- A framing `error` is registered 1 clock after the stop-bit sample.
- Back-to-back frames: the receiver is in IDLE in the cycle after the stop sample. A start edge arriving half a bit later is detected with no lost frame.
- Reset asserted mid-frame: all state clears immediately, any partial char or nibble is discarded, and no strobe is produced.

## Test plan
Benches run with `delay`=8, `counterBits`=4.
- Send "3A\n" (0x33, 0x41, 0x0A) -> exactly one `dataValid`, `data`=0x3A, `error` never high.
- Send "ff\r\n" -> `data`=0xFF with one `dataValid`. CR is ignored.
- Send "G1\n" then "05\n" -> one `error` on 'G', no strobe on the first LF, then `data`=0x05 with `dataValid`.
- Send a frame 0x41 with the stop bit forced to 0, hold the line low for 20 clocks, then send "7\n" -> one framing `error`. The next line gives a parse `error` on LF in P1 and no `dataValid`.
- Pulse `serialIn` low for 3 clocks (glitch) -> no strobe, `busy` drops back to 0, and the following "12\n" yields 0x12.
- Assert `resetN`=0 during bit 4 of '9' after '8' has been received, release, then send "AB\n" -> `data`=0xAB. Outputs stay at their reset values while reset is asserted.
